// File: rtl/key_command_decoder.sv
// ---------------------------------------------------------------------------
// key_command_decoder : pops UART bytes, normalizes WASD/space/enter keys,
// holds the decoded key for HOLD_CYCLES and flags repeated directions. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_command_decoder #(
   parameter int HOLD_CYCLES = 6500000,
   parameter int TURBO_COUNT = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_empty,
   input  logic [7:0] r_data,
   output logic       rd_uart,
   output logic [7:0] key_data,
   output logic       key_valid,
   output logic [3:0] dir,
   output logic       turbo,
   output logic [7:0] last_byte
);

   localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int RW = (TURBO_COUNT > 0) ? $clog2(TURBO_COUNT + 1) : 1;

   localparam logic [CW-1:0] c_HOLD_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);
   localparam logic [RW-1:0] c_TURBO_MAX = RW'(TURBO_COUNT);
   localparam logic [RW-1:0] c_REP_ONE   = RW'(1);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_DECODE = 2'd1;
   localparam logic [1:0] c_HOLD   = 2'd2;

   logic [1:0]    r_state;
   logic          r_ret_hold;
   logic [CW-1:0] r_cnt;
   logic [RW-1:0] r_rep;
   logic [7:0]    r_key;
   logic [3:0]    r_dir;
   logic          r_turbo;
   logic          r_kv;
   logic [7:0]    r_last;

   logic [7:0]    w_norm;
   logic [3:0]    w_dir;
   logic          w_ctrl;
   logic          w_accept;
   logic [RW-1:0] w_rep_next;
   logic          w_pop;

   always_comb begin
      w_norm = r_last;
      if ((r_last >= 8'h61) && (r_last <= 8'h7A)) begin
         w_norm = r_last - 8'h20;
      end
   end

   always_comb begin
      w_dir = 4'b0000;
      case (w_norm)
         8'h57:   w_dir = 4'b0001;
         8'h53:   w_dir = 4'b0010;
         8'h41:   w_dir = 4'b0100;
         8'h44:   w_dir = 4'b1000;
         default: w_dir = 4'b0000;
      endcase
   end

   assign w_ctrl   = (w_norm == 8'h20) || (w_norm == 8'h0D);
   assign w_accept = (w_dir != 4'b0000) || w_ctrl;

   // A direction matching the held one can only occur while a direction is held.
   always_comb begin
      w_rep_next = r_rep;
      if (w_ctrl) begin
         w_rep_next = '0;
      end else if (w_dir == r_dir) begin
         w_rep_next = (r_rep == c_TURBO_MAX) ? r_rep : (r_rep + c_REP_ONE);
      end else begin
         w_rep_next = c_REP_ONE;
      end
   end

   assign w_pop   = !rst && !rx_empty && ((r_state == c_IDLE) || (r_state == c_HOLD));
   assign rd_uart = w_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= c_IDLE;
         r_ret_hold <= 1'b0;
         r_cnt      <= '0;
         r_rep      <= '0;
         r_key      <= 8'h00;
         r_dir      <= 4'b0000;
         r_turbo    <= 1'b0;
         r_kv       <= 1'b0;
         r_last     <= 8'h00;
      end else begin
         r_kv <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (!rx_empty) begin
                  r_last     <= r_data;
                  r_ret_hold <= 1'b0;
                  r_state    <= c_DECODE;
               end
            end
            c_HOLD: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - c_CNT_ONE;
               end
               // A waiting byte wins over expiry; outputs stay held meanwhile.
               if (!rx_empty) begin
                  r_last     <= r_data;
                  r_ret_hold <= 1'b1;
                  r_state    <= c_DECODE;
               end else if (r_cnt == '0) begin
                  r_key   <= 8'h00;
                  r_dir   <= 4'b0000;
                  r_turbo <= 1'b0;
                  r_rep   <= '0;
                  r_state <= c_IDLE;
               end
            end
            c_DECODE: begin
               if (w_accept) begin
                  r_key   <= w_norm;
                  r_dir   <= w_dir;
                  r_kv    <= 1'b1;
                  r_cnt   <= c_HOLD_LOAD;
                  r_rep   <= w_rep_next;
                  r_turbo <= (w_rep_next == c_TURBO_MAX);
                  r_state <= c_HOLD;
               end else begin
                  r_state <= r_ret_hold ? c_HOLD : c_IDLE;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign key_data  = r_key;
   assign key_valid = r_kv;
   assign dir       = r_dir;
   assign turbo     = r_turbo;
   assign last_byte = r_last;

endmodule

`default_nettype wire

// File: tb/tb_key_command_decoder.sv
// ---------------------------------------------------------------------------
// tb_key_command_decoder : FIFO-driven stimulus checked every cycle against a
// behavioural key-hold model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_key_command_decoder;

   localparam int HC = 8;
   localparam int TC = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_empty;
   logic [7:0] r_data;
   logic       rd_uart;
   logic [7:0] key_data;
   logic       key_valid;
   logic [3:0] dir;
   logic       turbo;
   logic [7:0] last_byte;

   always #5 clk = ~clk;

   key_command_decoder #(
      .HOLD_CYCLES (HC),
      .TURBO_COUNT (TC)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .rx_empty  (rx_empty),
      .r_data    (r_data),
      .rd_uart   (rd_uart),
      .key_data  (key_data),
      .key_valid (key_valid),
      .dir       (dir),
      .turbo     (turbo),
      .last_byte (last_byte)
   );

   int checks = 0;
   int errors = 0;
   int pops   = 0;

   logic [7:0] fifo[$];
   bit         gate    = 1'b0;
   bit         rst_req = 1'b1;

   // Reference model state: what a user would observe, not how it is built.
   bit         m_decoding = 1'b0;
   bit         m_holding  = 1'b0;
   int         m_remain   = 0;
   logic [7:0] m_key      = 8'h00;
   logic [3:0] m_dir      = 4'b0000;
   logic [7:0] m_last     = 8'h00;
   int         m_rep      = 0;
   bit         m_kv       = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] norm(input logic [7:0] b);
      if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
      return b;
   endfunction

   function automatic logic [3:0] dmap(input logic [7:0] n);
      case (n)
         8'h57:   return 4'b0001;
         8'h53:   return 4'b0010;
         8'h41:   return 4'b0100;
         8'h44:   return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic drive_inputs();
      rst      = rst_req;
      rx_empty = gate || (fifo.size() == 0);
      r_data   = (fifo.size() != 0) ? fifo[0] : 8'($urandom);
   endtask

   task automatic push(input logic [7:0] b);
      fifo.push_back(b);
      drive_inputs();
   endtask

   task automatic model_edge(input bit pop, input logic [7:0] b);
      logic [7:0] n;
      logic [3:0] d;
      if (rst) begin
         m_decoding = 0; m_holding = 0; m_remain = 0; m_key = 8'h00;
         m_dir = 4'b0000; m_last = 8'h00; m_rep = 0; m_kv = 0;
      end else begin
         m_kv = 0;
         if (m_decoding) begin
            m_decoding = 0;
            n = norm(m_last);
            d = dmap(n);
            if (d != 4'b0000 || n == 8'h20 || n == 8'h0D) begin
               if (d == 4'b0000)   m_rep = 0;
               else if (d == m_dir) m_rep = (m_rep < TC) ? m_rep + 1 : TC;
               else                m_rep = 1;
               m_key     = n;
               m_dir     = d;
               m_kv      = 1;
               m_holding = 1;
               m_remain  = HC - 1;
            end
         end else if (pop) begin
            m_last     = b;
            m_decoding = 1;
            if (m_holding && m_remain > 0) m_remain--;
         end else if (m_holding) begin
            if (m_remain == 0) begin
               m_holding = 0; m_key = 8'h00; m_dir = 4'b0000; m_rep = 0;
            end else begin
               m_remain--;
            end
         end
      end
   endtask

   task automatic step();
      bit         exp_pop;
      logic [7:0] b;
      @(negedge clk);
      exp_pop = !rst && !rx_empty && !m_decoding;
      check_eq("rd_uart",   32'(rd_uart),   32'(exp_pop));
      check_eq("key_valid", 32'(key_valid), 32'(m_kv));
      check_eq("key_data",  32'(key_data),  32'(m_key));
      check_eq("dir",       32'(dir),       32'(m_dir));
      check_eq("turbo",     32'(turbo),     32'(m_rep == TC));
      check_eq("last_byte", 32'(last_byte), 32'(m_last));
      if (rd_uart) pops++;
      b = r_data;
      @(posedge clk);
      model_edge(exp_pop, b);
      if (exp_pop && fifo.size() != 0) void'(fifo.pop_front());
      #1;
      drive_inputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   logic [7:0] picks [12] = '{8'h77, 8'h57, 8'h61, 8'h41, 8'h73, 8'h53,
                              8'h64, 8'h44, 8'h20, 8'h0D, 8'h31, 8'h00};

   initial begin
      drive_inputs();
      @(posedge clk);
      #1;
      run(3);
      rst_req = 1'b0;
      drive_inputs();

      // single 'w'
      pops = 0;
      push(8'h77);
      run(14);
      check_eq("pops_single", 32'(pops), 32'd1);

      // three 'd' four cycles apart -> turbo
      push(8'h64); run(4);
      push(8'h64); run(4);
      push(8'h64); run(14);

      // 'd','d' then 'a' inside hold
      push(8'h64); run(4);
      push(8'h64); run(4);
      push(8'h61); run(14);

      // unrecognized byte while holding 's'
      push(8'h73); run(3);
      push(8'h31); run(14);

      // three queued bytes back to back
      pops = 0;
      push(8'h77); push(8'h78); push(8'h64);
      run(16);
      check_eq("pops_burst", 32'(pops), 32'd3);

      // reset in the middle of a space hold
      push(8'h20); run(4);
      rst_req = 1'b1; drive_inputs(); run(1);
      rst_req = 1'b0; drive_inputs(); run(1);
      push(8'h77); run(14);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 11) == 11) fifo.push_back(8'($urandom));
            else fifo.push_back(picks[$urandom_range(0, 10)]);
         end
         gate    = ($urandom_range(0, 3) == 0);
         rst_req = ($urandom_range(0, 120) == 0);
         drive_inputs();
         step();
      end

      gate    = 1'b0;
      rst_req = 1'b0;
      drive_inputs();
      run(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
